// File: rtl/sevenseg_scan_decoder_if.sv
// Bus between the multiplexed 7-segment display path and its scan decoder.
//   segmentIn   : active-low segments, [7:1] = a..g, [0] = dot
//   digitSelIn  : active-low digit enables, bit n selects digit n
//   digitsOut   : decoded BCD per digit, digit n in [4n+3:4n]
//   dotsOut     : per-digit dot lit flag
//   validOut    : per-digit "captured since reset" flag
//   errorOut    : per-digit "last capture was an unknown pattern" flag
//   frameDone   : one-cycle pulse per completed 4-digit frame
// master = display side (drives segments/selects), slave = decoder.
interface sevenseg_scan_decoder_if;
    logic [7:0]  segmentIn;
    logic [3:0]  digitSelIn;
    logic [15:0] digitsOut;
    logic [3:0]  dotsOut;
    logic [3:0]  validOut;
    logic [3:0]  errorOut;
    logic        frameDone;

    modport master (
        output segmentIn, digitSelIn,
        input  digitsOut, dotsOut, validOut, errorOut, frameDone
    );

    modport slave (
        input  segmentIn, digitSelIn,
        output digitsOut, dotsOut, validOut, errorOut, frameDone
    );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Scan decoder for a multiplexed 4-digit common-anode 7-segment bus.
// Waits for segment/select inputs to hold still for STABLE_CYCLES edges,
// then decodes the selected digit's pattern into BCD + dot + error flags,
// and pulses frameDone once all four digits have been captured.
//   clkIn   : system clock
//   resetIn : asynchronous, active-high reset
//   bus     : decoder side of sevenseg_scan_decoder_if (see interface header)
module sevenseg_scan_decoder #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                        clkIn,
    input  logic                        resetIn,
    sevenseg_scan_decoder_if.slave      bus
);
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {IDLE, SETTLE, CAPTURED} state_t;

    state_t      r_state, w_state_next;
    logic [7:0]  r_seg;
    logic [3:0]  r_sel;
    logic [7:0]  r_cnt, w_cnt_next;
    logic [3:0]  r_captured;
    logic [15:0] r_digits;
    logic [3:0]  r_dots, r_valid, r_error;
    logic        r_frame;

    logic        w_same, w_sel_ok, w_capture, w_bad;
    logic [1:0]  w_idx;
    logic [3:0]  w_val;

    // A select change alone counts as a change, so scan transitions restart
    // the settle window instead of producing ghost captures.
    assign w_same = ({bus.segmentIn, bus.digitSelIn} == {r_seg, r_sel});

    // Exactly one active-low enable is a usable select.
    always_comb begin
        w_sel_ok = 1'b1;
        w_idx    = 2'd0;
        case (bus.digitSelIn)
            4'hE:    w_idx = 2'd0;
            4'hD:    w_idx = 2'd1;
            4'hB:    w_idx = 2'd2;
            4'h7:    w_idx = 2'd3;
            default: w_sel_ok = 1'b0;
        endcase
    end

    always_comb begin
        w_cnt_next = 8'd0;
        if (w_sel_ok && w_same)
            w_cnt_next = (r_cnt == STABLE) ? STABLE : r_cnt + 8'd1;
    end

    // Segment pattern (dot excluded) to BCD; blank reads as 4'hA.
    always_comb begin
        w_bad = 1'b0;
        case (bus.segmentIn[7:1])
            7'h01:   w_val = 4'd0;
            7'h4F:   w_val = 4'd1;
            7'h12:   w_val = 4'd2;
            7'h06:   w_val = 4'd3;
            7'h4C:   w_val = 4'd4;
            7'h24:   w_val = 4'd5;
            7'h20:   w_val = 4'd6;
            7'h0F:   w_val = 4'd7;
            7'h00:   w_val = 4'd8;
            7'h04:   w_val = 4'd9;
            7'h7F:   w_val = 4'hA;
            default: begin
                w_val = 4'hF;
                w_bad = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            IDLE:
                if (w_sel_ok) w_state_next = SETTLE;
            SETTLE:
                if (!w_sel_ok) begin
                    w_state_next = IDLE;
                end else if (w_cnt_next == STABLE) begin
                    w_capture    = 1'b1;
                    w_state_next = CAPTURED;
                end
            CAPTURED:
                if (!w_sel_ok)    w_state_next = IDLE;
                else if (!w_same) w_state_next = SETTLE;
            default:
                w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_state    <= IDLE;
            r_seg      <= '0;
            r_sel      <= '0;
            r_cnt      <= '0;
            r_captured <= '0;
            r_digits   <= '0;
            r_dots     <= '0;
            r_valid    <= '0;
            r_error    <= '0;
            r_frame    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_seg   <= bus.segmentIn;
            r_sel   <= bus.digitSelIn;
            r_cnt   <= w_cnt_next;
            // Pulse follows the edge that completed the set; the set clears
            // on the pulse edge so the next frame starts empty.
            r_frame    <= (r_captured == 4'hF);
            r_captured <= ((r_captured == 4'hF) ? 4'h0 : r_captured)
                        | (w_capture ? ~bus.digitSelIn : 4'h0);
            if (w_capture) begin
                r_digits[{w_idx, 2'b00} +: 4] <= w_val;
                r_dots[w_idx]                 <= ~bus.segmentIn[0];
                r_error[w_idx]                <= w_bad;
                r_valid[w_idx]                <= 1'b1;
            end
        end
    end

    assign bus.digitsOut = r_digits;
    assign bus.dotsOut   = r_dots;
    assign bus.validOut  = r_valid;
    assign bus.errorOut  = r_error;
    assign bus.frameDone = r_frame;
endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: directed scenarios plus
// randomized scanning, checked against a run-length reference model
// through a per-cycle expected-output queue.
module tb_sevenseg_scan_decoder;
    localparam int S = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    sevenseg_scan_decoder_if bus();

    sevenseg_scan_decoder #(.STABLE_CYCLES(S)) dut (
        .clkIn   (clk),
        .resetIn (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  dots;
        logic [3:0]  vld;
        logic [3:0]  err;
        logic        fd;
    } snap_t;

    snap_t q[$];
    int    errors = 0;
    int    checks = 0;
    int    frame_pulses = 0;

    // reference model state
    snap_t      m;
    logic [3:0] m_cap;
    logic [7:0] m_pseg;
    logic [3:0] m_psel;
    int         m_run;

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        logic [6:0] tbl [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};
        for (int i = 0; i < 10; i++)
            if (p == tbl[i]) return {1'b0, 4'(i)};
        if (p == 7'h7F) return {1'b0, 4'hA};
        return {1'b1, 4'hF};
    endfunction

    function automatic snap_t dut_snap();
        snap_t s;
        s.d    = bus.digitsOut;
        s.dots = bus.dotsOut;
        s.vld  = bus.validOut;
        s.err  = bus.errorOut;
        s.fd   = bus.frameDone;
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: a digit is captured when the same valid {seg,sel} has been seen
    // on S+1 consecutive edges (the first of which starts the window).
    task automatic model_step();
        logic       sel_ok;
        logic       same;
        int         n;
        logic [4:0] dv;
        if (rst) begin
            m = '0; m_cap = '0; m_run = 0; m_pseg = '0; m_psel = '0;
            return;
        end
        sel_ok = ($countones(~bus.digitSelIn) == 1);
        same   = (bus.segmentIn == m_pseg) && (bus.digitSelIn == m_psel);
        m.fd   = (m_cap == 4'hF);
        if (m.fd) m_cap = '0;
        if (!sel_ok)   m_run = 0;
        else if (same) m_run++;
        else           m_run = 1;
        if (sel_ok && m_run == S + 1) begin
            n = 0;
            for (int k = 0; k < 4; k++) if (!bus.digitSelIn[k]) n = k;
            dv = ref_decode(bus.segmentIn[7:1]);
            m.d[n*4 +: 4] = dv[3:0];
            m.err[n]      = dv[4];
            m.dots[n]     = ~bus.segmentIn[0];
            m.vld[n]      = 1'b1;
            m_cap[n]      = 1'b1;
        end
        m_pseg = bus.segmentIn;
        m_psel = bus.digitSelIn;
        q.push_back(m);
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // Monitor: outputs are presented every cycle; compare against the queue.
    initial forever begin
        snap_t e;
        @(negedge clk);
        if (rst) begin
            q.delete();
            chk("reset_outputs", 32'(dut_snap()), 32'd0);
        end else if (q.size() > 0) begin
            e = q.pop_front();
            chk("scoreboard", 32'(dut_snap()), 32'(e));
            if (bus.frameDone) frame_pulses++;
        end
    end

    task automatic hold(input logic [7:0] s, input logic [3:0] d, input int n);
        bus.segmentIn  = s;
        bus.digitSelIn = d;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    logic [6:0] pats [11] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24,
                              7'h20, 7'h0F, 7'h00, 7'h04, 7'h7F};

    initial begin
        logic [3:0] sel;
        logic [7:0] seg;
        bus.segmentIn  = 8'hFF;
        bus.digitSelIn = 4'hF;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // single digit: 5, no dot
        frame_pulses = 0;
        hold(8'h49, 4'hE, 5);
        chk("single_digit0", 32'(bus.digitsOut[3:0]), 32'd5);
        chk("single_dots",   32'(bus.dotsOut), 32'd0);
        chk("single_valid",  32'(bus.validOut), 32'h1);
        chk("single_error",  32'(bus.errorOut), 32'd0);
        hold(8'h49, 4'hE, 20);
        chk("single_noframe", 32'(frame_pulses), 32'd0);

        // async reset mid-settle on digit 2
        hold(8'h25, 4'hB, 2);
        rst = 1'b1;
        #1;
        chk("reset_immediate", 32'(dut_snap()), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        hold(8'h25, 4'hB, 4);
        chk("reset_no_early_capture", 32'(bus.validOut), 32'd0);
        hold(8'h25, 4'hB, 1);
        chk("reset_capture_valid", 32'(bus.validOut), 32'h4);
        chk("reset_capture_digit", 32'(bus.digitsOut[11:8]), 32'd2);

        // settle filter on digit 1
        repeat (4) begin
            hold(8'h03, 4'hD, 3);
            hold(8'h9F, 4'hD, 3);
        end
        chk("filter_no_capture", 32'(bus.validOut[1]), 32'd0);
        hold(8'h9F, 4'hD, 5);
        chk("filter_capture", 32'(bus.digitsOut[7:4]), 32'd1);

        // full frame with dot on digit 2 and blank digit 3
        pulse_reset();
        frame_pulses = 0;
        hold(8'h9F, 4'hE, 6);
        hold(8'h01, 4'hD, 6);
        hold(8'h0C, 4'hB, 6);
        hold(8'hFF, 4'h7, 6);
        hold(8'hFF, 4'hF, 2);
        chk("frame_digits", 32'(bus.digitsOut), 32'hA381);
        chk("frame_dots",   32'(bus.dotsOut), 32'h4);
        chk("frame_valid",  32'(bus.validOut), 32'hF);
        chk("frame_pulses", 32'(frame_pulses), 32'd1);

        // unknown pattern, then recovery, then invalid selects
        hold(8'hAB, 4'hD, 6);
        chk("err_digit", 32'(bus.digitsOut[7:4]), 32'hF);
        chk("err_flag",  32'(bus.errorOut), 32'h2);
        hold(8'h0D, 4'hD, 6);
        chk("err_recover_digit", 32'(bus.digitsOut[7:4]), 32'd3);
        chk("err_recover_flag",  32'(bus.errorOut), 32'd0);
        hold(8'h0D, 4'hC, 10);
        hold(8'h0D, 4'hF, 10);
        chk("invalid_sel_digits", 32'(bus.digitsOut), 32'hA331);
        chk("invalid_sel_valid",  32'(bus.validOut), 32'hF);

        // randomized scanning
        for (int it = 0; it < 400; it++) begin
            if ($urandom_range(0, 9) < 8) sel = ~(4'h1 << $urandom_range(0, 3));
            else                          sel = 4'($urandom);
            if ($urandom_range(0, 3) != 0) seg = {pats[$urandom_range(0, 10)], 1'($urandom)};
            else                           seg = 8'($urandom);
            if ($urandom_range(0, 49) == 0) pulse_reset();
            hold(seg, sel, $urandom_range(1, 8));
        end
        hold(8'hFF, 4'hF, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
